// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard/stall scheduler.
package hazard_pkg;

  localparam int REG_ADDR_W = 5;
  localparam logic [REG_ADDR_W-1:0] REG_X0 = 5'd0;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    REDIRECT = 2'd2,
    LOAD_USE = 2'd3
  } hz_state_e;

endpackage

// File: rtl/hazard_ctl_if.sv
// Pipeline-side signals of the hazard scheduler: master = pipeline, slave = hazard_ctl.
interface hazard_ctl_if #(
  parameter int XLEN = 32
);
  import hazard_pkg::*;

  logic                  de_valid;
  logic [REG_ADDR_W-1:0] de_rs1;
  logic [REG_ADDR_W-1:0] de_rs2;
  logic                  de_uses_rs1;
  logic                  de_uses_rs2;
  logic                  ex_valid;
  logic [REG_ADDR_W-1:0] ex_rd;
  logic                  ex_is_load;
  logic                  ex_br_taken;
  logic [XLEN-1:0]       ex_br_target;
  logic                  mem_req;
  logic                  mem_ready;

  logic                  stall_if;
  logic                  stall_de;
  logic                  stall_ex;
  logic                  flush_de;
  logic                  flush_ex;
  logic                  pc_redirect;
  logic [XLEN-1:0]       pc_redirect_target;
  logic [1:0]            hz_state;

  modport master (
    output de_valid, de_rs1, de_rs2, de_uses_rs1, de_uses_rs2,
           ex_valid, ex_rd, ex_is_load, ex_br_taken, ex_br_target,
           mem_req, mem_ready,
    input  stall_if, stall_de, stall_ex, flush_de, flush_ex,
           pc_redirect, pc_redirect_target, hz_state
  );

  modport slave (
    input  de_valid, de_rs1, de_rs2, de_uses_rs1, de_uses_rs2,
           ex_valid, ex_rd, ex_is_load, ex_br_taken, ex_br_target,
           mem_req, mem_ready,
    output stall_if, stall_de, stall_ex, flush_de, flush_ex,
           pc_redirect, pc_redirect_target, hz_state
  );

endinterface

// File: rtl/hazard_cmp.sv
// Source-vs-destination register match for one decode operand; x0 never matches.
module hazard_cmp
  import hazard_pkg::*;
(
  input  logic                  de_valid,
  input  logic                  uses,
  input  logic [REG_ADDR_W-1:0] rs,
  input  logic                  ex_valid,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  output logic                  match
);

  assign match = de_valid & uses & ex_valid & (ex_rd != REG_X0) & (rs == ex_rd);

endmodule

// File: rtl/hazard_ctl.sv
// Hazard/stall scheduler: load-use, data-memory wait and branch redirect control.
// Optional performance counters are enabled by defining HAZARD_PERF_CNT_EN.
module hazard_ctl
  import hazard_pkg::*;
#(
  parameter int XLEN             = 32,
  parameter int REDIRECT_BUBBLES = 1,
  parameter int CNT_W            = 32
) (
  input  logic             clk,
  input  logic             rst,
  hazard_ctl_if.slave      hz
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] perf_stall_cyc,
  output logic [CNT_W-1:0] perf_flush_evt
`endif
);

  localparam logic [2:0] BUB_INIT = 3'(REDIRECT_BUBBLES);

  hz_state_e       state, state_nxt;
  logic [2:0]      bub_cnt, bub_nxt;
  logic            match_rs1, match_rs2;
  logic            load_use, mem_wait, br_redirect;
  logic            s_if, s_de, s_ex, f_de, f_ex, redir;
  logic [XLEN-1:0] br_target;

  assign br_target = hz.ex_br_target;

  hazard_cmp u_cmp_rs1 (
    .de_valid (hz.de_valid),
    .uses     (hz.de_uses_rs1),
    .rs       (hz.de_rs1),
    .ex_valid (hz.ex_valid),
    .ex_rd    (hz.ex_rd),
    .match    (match_rs1)
  );

  hazard_cmp u_cmp_rs2 (
    .de_valid (hz.de_valid),
    .uses     (hz.de_uses_rs2),
    .rs       (hz.de_rs2),
    .ex_valid (hz.ex_valid),
    .ex_rd    (hz.ex_rd),
    .match    (match_rs2)
  );

  assign load_use    = hz.ex_is_load & (match_rs1 | match_rs2);
  assign mem_wait    = hz.mem_req & ~hz.mem_ready;
  assign br_redirect = hz.ex_valid & hz.ex_br_taken;

  // A memory wait inside REDIRECT freezes the bubble count so the flush resumes afterwards.
  always_comb begin
    s_if      = 1'b0;
    s_de      = 1'b0;
    s_ex      = 1'b0;
    f_de      = 1'b0;
    f_ex      = 1'b0;
    redir     = 1'b0;
    state_nxt = state;
    bub_nxt   = bub_cnt;
    if (rst) begin
      f_de      = 1'b1;
      f_ex      = 1'b1;
      state_nxt = RUN;
      bub_nxt   = 3'd0;
    end else begin
      case (state)
        RUN: begin
          if (mem_wait) begin
            s_if      = 1'b1;
            s_de      = 1'b1;
            s_ex      = 1'b1;
            state_nxt = MEM_WAIT;
          end else if (br_redirect) begin
            redir = 1'b1;
            f_de  = 1'b1;
            f_ex  = 1'b1;
            if (REDIRECT_BUBBLES > 0) begin
              state_nxt = REDIRECT;
              bub_nxt   = BUB_INIT;
            end
          end else if (load_use) begin
            s_if      = 1'b1;
            s_de      = 1'b1;
            f_ex      = 1'b1;
            state_nxt = LOAD_USE;
          end
        end
        MEM_WAIT: begin
          if (!hz.mem_ready) begin
            s_if = 1'b1;
            s_de = 1'b1;
            s_ex = 1'b1;
          end else begin
            state_nxt = RUN;
          end
        end
        REDIRECT: begin
          if (mem_wait) begin
            s_if = 1'b1;
            s_de = 1'b1;
            s_ex = 1'b1;
          end else begin
            f_de = 1'b1;
            if (bub_cnt <= 3'd1) begin
              state_nxt = RUN;
              bub_nxt   = 3'd0;
            end else begin
              bub_nxt = bub_cnt - 3'd1;
            end
          end
        end
        LOAD_USE: begin
          if (mem_wait) begin
            s_if      = 1'b1;
            s_de      = 1'b1;
            s_ex      = 1'b1;
            state_nxt = MEM_WAIT;
          end else begin
            state_nxt = RUN;
          end
        end
        default: state_nxt = RUN;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= RUN;
      bub_cnt <= 3'd0;
    end else begin
      state   <= state_nxt;
      bub_cnt <= bub_nxt;
    end
  end

  assign hz.stall_if           = s_if;
  assign hz.stall_de           = s_de;
  assign hz.stall_ex           = s_ex;
  assign hz.flush_de           = f_de;
  assign hz.flush_ex           = f_ex;
  assign hz.pc_redirect        = redir;
  assign hz.pc_redirect_target = redir ? br_target : '0;
  assign hz.hz_state           = state;

`ifdef HAZARD_PERF_CNT_EN
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_stall_cyc <= '0;
      perf_flush_evt <= '0;
    end else begin
      if (s_if) perf_stall_cyc <= perf_stall_cyc + CNT_ONE;
      if (redir) perf_flush_evt <= perf_flush_evt + CNT_ONE;
    end
  end
`else
  logic unused_cnt_w;
  assign unused_cnt_w = (CNT_W > 0);
`endif

endmodule

// File: tb/tb_hazard_ctl.sv
// Table-driven self-checking bench for hazard_ctl (REDIRECT_BUBBLES=2); covers HAZARD_PERF_CNT_EN when defined.
module tb_hazard_ctl;
  import hazard_pkg::*;

  localparam int SEG_A_END = 12;

  typedef struct packed {
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [5:0]  flags;   // {de_valid, uses_rs1, uses_rs2, ex_valid, ex_is_load, ex_br_taken}
    logic [1:0]  mem;     // {mem_req, mem_ready}
    logic [31:0] tgt;
    logic [2:0]  exp_stall; // {if, de, ex}
    logic [1:0]  exp_flush; // {de, ex}
    logic        exp_redir;
    logic [1:0]  exp_state;
  } vec_t;

  typedef struct packed {
    logic [2:0]  stall;
    logic [1:0]  flush;
    logic        redir;
    logic [31:0] tgt;
    logic [1:0]  state;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail = 0;
  exp_t exp_q[$];
  vec_t tbl[$];

  hazard_ctl_if #(.XLEN(32)) hz_if ();

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] perf_stall_cyc;
  logic [31:0] perf_flush_evt;
`endif

  hazard_ctl #(
    .XLEN             (32),
    .REDIRECT_BUBBLES (2),
    .CNT_W            (32)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .hz             (hz_if)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .perf_stall_cyc (perf_stall_cyc),
    .perf_flush_evt (perf_flush_evt)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic vec_t mk(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                              input logic [5:0] flags, input logic [1:0] mem, input logic [31:0] tgt,
                              input logic [2:0] st, input logic [1:0] fl, input logic rdr,
                              input logic [1:0] hs);
    vec_t v;
    v.rs1 = rs1; v.rs2 = rs2; v.rd = rd; v.flags = flags; v.mem = mem; v.tgt = tgt;
    v.exp_stall = st; v.exp_flush = fl; v.exp_redir = rdr; v.exp_state = hs;
    return v;
  endfunction

  task automatic check(input string lbl, input string what, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s %s: got %0h expected %0h", lbl, what, act, exp);
    end
  endtask

  task automatic driveIdle();
    hz_if.de_valid = 1'b0; hz_if.de_rs1 = 5'd0; hz_if.de_rs2 = 5'd0;
    hz_if.de_uses_rs1 = 1'b0; hz_if.de_uses_rs2 = 1'b0;
    hz_if.ex_valid = 1'b0; hz_if.ex_rd = 5'd0; hz_if.ex_is_load = 1'b0;
    hz_if.ex_br_taken = 1'b0; hz_if.ex_br_target = 32'h0;
    hz_if.mem_req = 1'b0; hz_if.mem_ready = 1'b0;
  endtask

  task automatic applyStimulus(input vec_t v);
    exp_t e;
    @(posedge clk);
    #1;
    hz_if.de_rs1 = v.rs1; hz_if.de_rs2 = v.rs2; hz_if.ex_rd = v.rd;
    {hz_if.de_valid, hz_if.de_uses_rs1, hz_if.de_uses_rs2,
     hz_if.ex_valid, hz_if.ex_is_load, hz_if.ex_br_taken} = v.flags;
    {hz_if.mem_req, hz_if.mem_ready} = v.mem;
    hz_if.ex_br_target = v.tgt;
    e.stall = v.exp_stall;
    e.flush = v.exp_flush;
    e.redir = v.exp_redir;
    e.tgt   = v.exp_redir ? v.tgt : 32'h0;
    e.state = v.exp_state;
    exp_q.push_back(e);
  endtask

  task automatic checkOutput(input string lbl);
    exp_t e;
    @(negedge clk);
    if (exp_q.size() == 0) begin
      check(lbl, "scoreboard_empty", 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      check(lbl, "stall", 32'({hz_if.stall_if, hz_if.stall_de, hz_if.stall_ex}), 32'(e.stall));
      check(lbl, "flush", 32'({hz_if.flush_de, hz_if.flush_ex}), 32'(e.flush));
      check(lbl, "pc_redirect", 32'(hz_if.pc_redirect), 32'(e.redir));
      check(lbl, "target", hz_if.pc_redirect_target, e.tgt);
      check(lbl, "hz_state", 32'(hz_if.hz_state), 32'(e.state));
    end
  endtask

  initial begin
    // Segment A: load-use, redirect, memory wait without pending branch
    tbl.push_back(mk(5'd5, 5'd1, 5'd5, 6'b111110, 2'b00, 32'h0,   3'b110, 2'b01, 1'b0, 2'd0));
    tbl.push_back(mk(5'd5, 5'd1, 5'd5, 6'b111000, 2'b00, 32'h0,   3'b000, 2'b00, 1'b0, 2'd3));
    tbl.push_back(mk(5'd0, 5'd0, 5'd0, 6'b000000, 2'b00, 32'h0,   3'b000, 2'b00, 1'b0, 2'd0));
    tbl.push_back(mk(5'd0, 5'd0, 5'd0, 6'b000101, 2'b00, 32'h100, 3'b000, 2'b11, 1'b1, 2'd0));
    tbl.push_back(mk(5'd0, 5'd0, 5'd0, 6'b000000, 2'b00, 32'h0,   3'b000, 2'b10, 1'b0, 2'd2));
    tbl.push_back(mk(5'd0, 5'd0, 5'd0, 6'b000000, 2'b00, 32'h0,   3'b000, 2'b10, 1'b0, 2'd2));
    tbl.push_back(mk(5'd0, 5'd0, 5'd0, 6'b000000, 2'b00, 32'h0,   3'b000, 2'b00, 1'b0, 2'd0));
    tbl.push_back(mk(5'd0, 5'd0, 5'd0, 6'b000000, 2'b10, 32'h0,   3'b111, 2'b00, 1'b0, 2'd0));
    tbl.push_back(mk(5'd0, 5'd0, 5'd0, 6'b000000, 2'b10, 32'h0,   3'b111, 2'b00, 1'b0, 2'd1));
    tbl.push_back(mk(5'd0, 5'd0, 5'd0, 6'b000000, 2'b10, 32'h0,   3'b111, 2'b00, 1'b0, 2'd1));
    tbl.push_back(mk(5'd0, 5'd0, 5'd0, 6'b000000, 2'b10, 32'h0,   3'b111, 2'b00, 1'b0, 2'd1));
    tbl.push_back(mk(5'd0, 5'd0, 5'd0, 6'b000000, 2'b11, 32'h0,   3'b000, 2'b00, 1'b0, 2'd1));
    tbl.push_back(mk(5'd0, 5'd0, 5'd0, 6'b000000, 2'b00, 32'h0,   3'b000, 2'b00, 1'b0, 2'd0));
    // Segment B: non-hazards, rs2 and back-to-back load-use, combined cases
    tbl.push_back(mk(5'd0, 5'd0, 5'd0, 6'b111110, 2'b00, 32'h0,   3'b000, 2'b00, 1'b0, 2'd0));
    tbl.push_back(mk(5'd5, 5'd1, 5'd5, 6'b101110, 2'b00, 32'h0,   3'b000, 2'b00, 1'b0, 2'd0));
    tbl.push_back(mk(5'd5, 5'd1, 5'd5, 6'b011110, 2'b00, 32'h0,   3'b000, 2'b00, 1'b0, 2'd0));
    tbl.push_back(mk(5'd5, 5'd1, 5'd5, 6'b111100, 2'b00, 32'h0,   3'b000, 2'b00, 1'b0, 2'd0));
    tbl.push_back(mk(5'd3, 5'd7, 5'd7, 6'b111110, 2'b00, 32'h0,   3'b110, 2'b01, 1'b0, 2'd0));
    tbl.push_back(mk(5'd3, 5'd7, 5'd7, 6'b111110, 2'b00, 32'h0,   3'b000, 2'b00, 1'b0, 2'd3));
    tbl.push_back(mk(5'd9, 5'd2, 5'd9, 6'b111110, 2'b00, 32'h0,   3'b110, 2'b01, 1'b0, 2'd0));
    tbl.push_back(mk(5'd9, 5'd2, 5'd9, 6'b111000, 2'b00, 32'h0,   3'b000, 2'b00, 1'b0, 2'd3));
    tbl.push_back(mk(5'd5, 5'd1, 5'd5, 6'b111111, 2'b00, 32'h200, 3'b000, 2'b11, 1'b1, 2'd0));
    tbl.push_back(mk(5'd5, 5'd1, 5'd5, 6'b111110, 2'b00, 32'h0,   3'b000, 2'b10, 1'b0, 2'd2));
    tbl.push_back(mk(5'd5, 5'd1, 5'd5, 6'b111110, 2'b00, 32'h0,   3'b000, 2'b10, 1'b0, 2'd2));
    tbl.push_back(mk(5'd0, 5'd0, 5'd0, 6'b000000, 2'b00, 32'h0,   3'b000, 2'b00, 1'b0, 2'd0));
    tbl.push_back(mk(5'd0, 5'd0, 5'd0, 6'b000101, 2'b10, 32'h300, 3'b111, 2'b00, 1'b0, 2'd0));
    tbl.push_back(mk(5'd0, 5'd0, 5'd0, 6'b000101, 2'b10, 32'h300, 3'b111, 2'b00, 1'b0, 2'd1));
    tbl.push_back(mk(5'd0, 5'd0, 5'd0, 6'b000101, 2'b10, 32'h300, 3'b111, 2'b00, 1'b0, 2'd1));
    tbl.push_back(mk(5'd0, 5'd0, 5'd0, 6'b000101, 2'b10, 32'h300, 3'b111, 2'b00, 1'b0, 2'd1));
    tbl.push_back(mk(5'd0, 5'd0, 5'd0, 6'b000101, 2'b11, 32'h300, 3'b000, 2'b00, 1'b0, 2'd1));
    tbl.push_back(mk(5'd0, 5'd0, 5'd0, 6'b000101, 2'b00, 32'h300, 3'b000, 2'b11, 1'b1, 2'd0));
    tbl.push_back(mk(5'd0, 5'd0, 5'd0, 6'b000000, 2'b00, 32'h0,   3'b000, 2'b10, 1'b0, 2'd2));
    tbl.push_back(mk(5'd0, 5'd0, 5'd0, 6'b000000, 2'b00, 32'h0,   3'b000, 2'b10, 1'b0, 2'd2));
    tbl.push_back(mk(5'd0, 5'd0, 5'd0, 6'b000000, 2'b00, 32'h0,   3'b000, 2'b00, 1'b0, 2'd0));

    driveIdle();
    #2;
    check("reset", "stall", 32'({hz_if.stall_if, hz_if.stall_de, hz_if.stall_ex}), 32'd0);
    check("reset", "flush", 32'({hz_if.flush_de, hz_if.flush_ex}), 32'd3);
    check("reset", "pc_redirect", 32'(hz_if.pc_redirect), 32'd0);
    check("reset", "hz_state", 32'(hz_if.hz_state), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      applyStimulus(tbl[i]);
      checkOutput($sformatf("vec%0d", i));
`ifdef HAZARD_PERF_CNT_EN
      if (i == SEG_A_END) begin
        check("perf", "stall_cyc", perf_stall_cyc, 32'd5);
        check("perf", "flush_evt", perf_flush_evt, 32'd1);
      end
`endif
    end

    // Reset asserted while parked in MEM_WAIT
    @(posedge clk);
    #1;
    driveIdle();
    hz_if.mem_req = 1'b1;
    @(negedge clk);
    check("rst_mw", "stall_enter", 32'({hz_if.stall_if, hz_if.stall_de, hz_if.stall_ex}), 32'd7);
    @(negedge clk);
    check("rst_mw", "state_wait", 32'(hz_if.hz_state), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("rst_mw", "hz_state", 32'(hz_if.hz_state), 32'd0);
    check("rst_mw", "stall", 32'({hz_if.stall_if, hz_if.stall_de, hz_if.stall_ex}), 32'd0);
    check("rst_mw", "flush", 32'({hz_if.flush_de, hz_if.flush_ex}), 32'd3);
`ifdef HAZARD_PERF_CNT_EN
    check("rst_mw", "perf_stall", perf_stall_cyc, 32'd0);
    check("rst_mw", "perf_flush", perf_flush_evt, 32'd0);
`endif
    @(posedge clk);
    #1;
    rst = 1'b0;
    hz_if.mem_req = 1'b0;
    @(negedge clk);
    check("post_rst", "hz_state", 32'(hz_if.hz_state), 32'd0);
    check("post_rst", "stall", 32'({hz_if.stall_if, hz_if.stall_de, hz_if.stall_ex}), 32'd0);
    check("post_rst", "flush", 32'({hz_if.flush_de, hz_if.flush_ex}), 32'd0);
    check("post_rst", "pc_redirect", 32'(hz_if.pc_redirect), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
